// File: rtl/gpr_dbg_access.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gpr_dbg_access
//
// Host-to-core register-file access responder. A single read or write request
// from the debug bridge is accepted, the core is asked to halt, and once the
// core acknowledges the halt the access is performed on the GPR file through a
// priority debug port. The result is then returned to the host.
//
// Ports
//   clock, reset              core clock, synchronous active-high reset
//   req_valid/req_ready       host request handshake
//   req_write/addr/wdata      request payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        read data (or written value), halt-timeout flag
//   halt_req, halt_ack        core stall request / core-is-stalled ack
//   gpr_raddr, gpr_rdata      regfile debug read port (combinational read)
//   gpr_wen/waddr/wdata       regfile debug write port (beats the core port)
//   dbg_state_o               current FSM state, for observation
//
// Handshake rule (both req and rsp): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge. ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module gpr_dbg_access #(
  parameter int XLEN         = 64,
  parameter int NREG         = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(NREG)-1:0]  req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_rdata,
  output logic                     rsp_err,
  output logic                     halt_req,
  input  logic                     halt_ack,
  output logic [$clog2(NREG)-1:0]  gpr_raddr,
  input  logic [XLEN-1:0]          gpr_rdata,
  output logic                     gpr_wen,
  output logic [$clog2(NREG)-1:0]  gpr_waddr,
  output logic [XLEN-1:0]          gpr_wdata,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HALT_WAIT = 2'd1,
    S_ACCESS    = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [AW-1:0]     addr_q,  addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic [CW-1:0]     cnt_q,   cnt_d;

  logic              in_access;
  logic              wen_int;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // req_ready is 1 throughout IDLE, so req_valid alone means accept.
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the same cycle as the timeout still wins.
        if (halt_ack) begin
          state_d = S_ACCESS;
        end else if (cnt_q == CW'(HALT_TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ACCESS: begin
        // x0 is hard-wired zero: reads return 0, writes are dropped silently.
        if (addr_q == '0) begin
          rdata_d = '0;
        end else if (write_q) begin
          rdata_d = wdata_q;
        end else begin
          rdata_d = gpr_rdata;
        end
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs come from registers or a state decode.
  assign in_access   = (state_q == S_ACCESS);
  assign wen_int     = in_access && write_q && (addr_q != '0);

  assign req_ready   = (state_q == S_IDLE);
  assign halt_req    = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign gpr_raddr   = in_access ? addr_q : '0;
  assign gpr_wen     = wen_int;
  assign gpr_waddr   = wen_int ? addr_q : '0;
  assign gpr_wdata   = wen_int ? wdata_q : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpr_dbg_access.sv
`timescale 1ns/1ps
module tb_gpr_dbg_access;

  localparam int XLEN = 64;
  localparam int HT   = 255;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [4:0]      req_addr  = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            halt_req;
  logic            halt_ack  = 1'b0;
  logic [4:0]      gpr_raddr;
  logic [XLEN-1:0] gpr_rdata;
  logic            gpr_wen;
  logic [4:0]      gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;
  logic [1:0]      dbg_state_o;

  gpr_dbg_access #(.XLEN(XLEN), .NREG(32), .HALT_TIMEOUT(HT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .halt_req(halt_req), .halt_ack(halt_ack),
    .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata), .gpr_wen(gpr_wen),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .dbg_state_o(dbg_state_o)
  );

  // ---------------- register file seen by the DUT ----------------
  function automatic logic [63:0] init_val(input int i);
    logic [4:0] a;
    a = i[4:0];
    if (i == 0) return 64'hBAD0_BAD0_BAD0_BAD0;  // must never leak out as x0
    if (i == 5) return 64'hDEADBEEF_00000005;
    return {32'hC0DE0000, 27'd0, a};
  endfunction

  logic [63:0] rf [32];
  logic        rf_load = 1'b1;
  assign gpr_rdata = rf[gpr_raddr];
  always @(posedge clock) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (gpr_wen) begin
      rf[gpr_waddr] <= gpr_wdata;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [64:0] exp_q[$];          // {err, rdata}
  logic [63:0] ref_rf [32];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of a request: x0 reads as zero, x0 writes vanish,
  // a timed-out request changes nothing and reports err with zero data.
  function automatic logic [64:0] model_req(input bit wr, input logic [4:0] a,
                                            input logic [63:0] wd, input bit timed_out);
    if (timed_out) return {1'b1, 64'd0};
    if (wr) begin
      if (a != 5'd0) ref_rf[a] = wd;
      return {1'b0, (a != 5'd0) ? wd : 64'd0};
    end
    return {1'b0, (a != 5'd0) ? ref_rf[a] : 64'd0};
  endfunction

  function automatic int lat_of(input int ack_dly);
    if (ack_dly >= 0 && ack_dly <= HT) return ack_dly + 3;
    return HT + 2;
  endfunction

  // ---------------- driver ----------------
  // Entered at the negedge of an IDLE cycle (cycle 0); returns at the negedge
  // of the cycle after the response handshake. ack_dly < 0 means never ack.
  task automatic run_txn(input bit wr, input logic [4:0] a, input logic [63:0] wd,
                         input int ack_dly, input int stall, input int exp_lat,
                         input int exp_wen, input bit keep_valid);
    int          cyc, wen_cnt, first_rsp, stall_left;
    bit          done, busy_ok;
    logic [64:0] exp;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    halt_ack  = 1'b0; rsp_ready = 1'b0;
    check("req_ready_idle", {64'd0, req_ready}, 65'd1);
    exp = '0;
    if (exp_q.size() == 0) check("exp_q_empty", 65'd0, 65'd1);
    else exp = exp_q.pop_front();
    cyc = 0; wen_cnt = 0; first_rsp = -1; stall_left = stall;
    done = 1'b0; busy_ok = 1'b1;
    while (!done && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (!keep_valid) req_valid = 1'b0;
      if (req_ready || !halt_req) busy_ok = 1'b0;
      if (gpr_wen) begin
        wen_cnt++;
        check("wen_waddr", {60'd0, gpr_waddr}, {60'd0, a});
        check("wen_wdata", {1'b0, gpr_wdata}, {1'b0, wd});
      end
      if (rsp_valid) begin
        if (first_rsp < 0) begin
          first_rsp = cyc;
          check("rsp_latency", 65'(first_rsp), 65'(exp_lat));
        end
        check("rsp_payload", {rsp_err, rsp_rdata}, exp);
        if (stall_left == 0) begin
          rsp_ready = 1'b1;
          done = 1'b1;
        end else begin
          stall_left--;
        end
      end
      halt_ack = (ack_dly >= 0 && cyc >= 1 + ack_dly);
    end
    if (!done) check("txn_cycle_budget", 65'd0, 65'd1);
    @(negedge clock);
    rsp_ready = 1'b0; halt_ack = 1'b0;
    check("post_hs_halt_req", {64'd0, halt_req}, 65'd0);
    check("post_hs_req_ready", {64'd0, req_ready}, 65'd1);
    check("post_hs_rsp_valid", {64'd0, rsp_valid}, 65'd0);
    check("wen_pulse_count", 65'(wen_cnt), 65'(exp_wen));
    check("busy_ready_halt", {64'd0, busy_ok}, 65'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, {63'd0, dbg_state_o}, 65'd0);
    check({tag, "_rsp_valid"}, {64'd0, rsp_valid}, 65'd0);
    check({tag, "_halt_req"}, {64'd0, halt_req}, 65'd0);
    check({tag, "_gpr_wen"}, {64'd0, gpr_wen}, 65'd0);
    check({tag, "_req_ready"}, {64'd0, req_ready}, 65'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [63:0] wdata;
    int          ack_dly;
    int          stall;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_wen;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 5'd5,  64'h0,      0,  0, 64'hDEADBEEF_00000005, 0, 3,   0};
    vecs[1] = '{1, 5'd31, 64'h1234,   0,  0, 64'h1234,              0, 3,   1};
    vecs[2] = '{0, 5'd31, 64'h0,      0,  0, 64'h1234,              0, 3,   0};
    vecs[3] = '{1, 5'd0,  64'hFFFF,   0,  0, 64'h0,                 0, 3,   0};
    vecs[4] = '{0, 5'd0,  64'h0,      0,  0, 64'h0,                 0, 3,   0};
    vecs[5] = '{0, 5'd5,  64'h0,     -1,  0, 64'h0,                 1, 257, 0};
    vecs[6] = '{1, 5'd3,  64'hAAAA,  -1,  0, 64'h0,                 1, 257, 0};
    vecs[7] = '{0, 5'd3,  64'h0,      2,  0, 64'hC0DE0000_00000003, 0, 5,   0};
    vecs[8] = '{1, 5'd1,  64'h5555, 255,  0, 64'h5555,              0, 258, 1};
    vecs[9] = '{0, 5'd1,  64'h0,     10,  5, 64'h5555,              0, 13,  0};

    for (int i = 0; i < 32; i++) ref_rf[i] = init_val(i);

    // Reset values.
    repeat (3) @(negedge clock);
    check_idle("reset");
    check("reset_rsp_err", {64'd0, rsp_err}, 65'd0);
    check("reset_rsp_rdata", {1'b0, rsp_rdata}, 65'd0);
    check("reset_gpr_raddr", {60'd0, gpr_raddr}, 65'd0);
    check("reset_gpr_waddr", {60'd0, gpr_waddr}, 65'd0);
    check("reset_gpr_wdata", {1'b0, gpr_wdata}, 65'd0);
    reset = 1'b0; rf_load = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < 10; i++) begin
      void'(model_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].ack_dly < 0 || vecs[i].ack_dly > HT));
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_dly,
              vecs[i].stall, vecs[i].exp_lat, vecs[i].exp_wen, 1'b0);
    end

    // Back-to-back: second request held valid during the first one.
    exp_q.push_back(model_req(0, 5'd31, 64'h0, 0));
    exp_q.push_back(model_req(0, 5'd31, 64'h0, 0));
    run_txn(0, 5'd31, 64'h0, 10, 5, 13, 0, 1'b1);
    run_txn(0, 5'd31, 64'h0, 10, 5, 13, 0, 1'b0);

    // Reset during ACCESS of a write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 64'h7777;
    halt_ack = 1'b1; rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    check("rstA_halt_wait", {63'd0, dbg_state_o}, 65'd1);
    @(negedge clock);
    check("rstA_access_wen", {64'd0, gpr_wen}, 65'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle("rstA");
    reset = 1'b0; halt_ack = 1'b0;
    exp_q.push_back(model_req(1, 5'd7, 64'h1111, 0));
    run_txn(1, 5'd7, 64'h1111, 0, 0, 3, 1, 1'b0);
    exp_q.push_back(model_req(0, 5'd7, 64'h0, 0));
    run_txn(0, 5'd7, 64'h0, 1, 0, 4, 0, 1'b0);

    // Reset during RESP.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5; req_wdata = 64'h0;
    halt_ack = 1'b1; rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rstB_rsp_valid", {64'd0, rsp_valid}, 65'd1);
    check("rstB_rsp_data", {rsp_err, rsp_rdata}, {1'b0, ref_rf[5]});
    reset = 1'b1;
    @(negedge clock);
    check_idle("rstB");
    reset = 1'b0; halt_ack = 1'b0;
    exp_q.push_back(model_req(0, 5'd5, 64'h0, 0));
    run_txn(0, 5'd5, 64'h0, 0, 0, 3, 0, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      logic [4:0]  a;
      logic [63:0] wd;
      int          d, st;
      wr = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      d  = $urandom_range(0, 12);
      st = $urandom_range(0, 4);
      exp_q.push_back(model_req(wr, a, wd, 0));
      run_txn(wr, a, wd, d, st, lat_of(d), (wr && a != 5'd0) ? 1 : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
